// File: rtl/periodic_req_sched_if.sv
// Config and request handshake bundle for periodic_req_sched.
// The cfg_oneshot wire exists only when SCHED_ONESHOT_EN is defined.
interface periodic_req_sched_if #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned PERW = 16
);
  localparam int unsigned CHW = $clog2(NCH);

  logic            cfg_we;
  logic [CHW-1:0]  cfg_ch;
  logic [PERW-1:0] cfg_period;
  logic            cfg_en;
`ifdef SCHED_ONESHOT_EN
  logic            cfg_oneshot;
`endif
  logic            req_valid;
  logic [CHW-1:0]  req_ch;
  logic            req_ready;

`ifdef SCHED_ONESHOT_EN
  modport master (
    input  cfg_we, cfg_ch, cfg_period, cfg_en, cfg_oneshot, req_ready,
    output req_valid, req_ch
  );
  modport slave (
    output cfg_we, cfg_ch, cfg_period, cfg_en, cfg_oneshot, req_ready,
    input  req_valid, req_ch
  );
`else
  modport master (
    input  cfg_we, cfg_ch, cfg_period, cfg_en, req_ready,
    output req_valid, req_ch
  );
  modport slave (
    output cfg_we, cfg_ch, cfg_period, cfg_en, req_ready,
    input  req_valid, req_ch
  );
`endif
endinterface

// File: rtl/periodic_req_sched.sv
// Periodic request scheduler: base-tick prescaler, NCH period counters, round-robin grant.
// Optional one-shot channels are enabled with the SCHED_ONESHOT_EN macro.
module periodic_req_sched_chk #(
  parameter int unsigned NCH = 4
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    req_valid_i,
  input logic                    req_ready_i,
  input logic [$clog2(NCH)-1:0]  req_ch_i,
  input logic [NCH-1:0]          pending_i
);
  // A presented request holds until accepted and always names a pending channel.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (req_valid_i && !req_ready_i) |=> (req_valid_i && $stable(req_ch_i)));
  a_pend: assert property (@(posedge clk) disable iff (rst)
    req_valid_i |-> pending_i[req_ch_i]);
endmodule

module periodic_req_sched #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned BASE_HZ = 1000,
  parameter int unsigned NCH     = 4,
  parameter int unsigned PERW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  periodic_req_sched_if.master  bus,
  output logic                  base_tick_o,
  output logic [NCH-1:0]        pending_o,
  output logic [NCH-1:0]        overrun_o
);
  // DIV must be at least 2 so the tick is a true single-cycle pulse.
  localparam int unsigned DIV = CLK_HZ / BASE_HZ;
  localparam int unsigned PSW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CHW = $clog2(NCH);
  localparam logic [PSW-1:0] PS_LAST = PSW'(DIV - 1);

  logic [PSW-1:0]  presc_q, presc_d;
  logic            base_tick_q, base_tick_d;
  logic [PERW-1:0] period_q [NCH];
  logic [PERW-1:0] period_d [NCH];
  logic [PERW-1:0] cnt_q [NCH];
  logic [PERW-1:0] cnt_d [NCH];
  logic [NCH-1:0]  en_q, en_d;
`ifdef SCHED_ONESHOT_EN
  logic [NCH-1:0]  oneshot_q, oneshot_d;
`endif
  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  overrun_q, overrun_d;
  logic            req_valid_q, req_valid_d;
  logic [CHW-1:0]  req_ch_q, req_ch_d;
  logic [CHW-1:0]  ptr_q, ptr_d;

  logic            hs_s;
  logic [NCH-1:0]  ack_s;
  logic [NCH-1:0]  cfg_hit_s;
  logic [NCH-1:0]  fire_s;
  logic [NCH-1:0]  cand_s;
  logic            found_s;
  logic [CHW-1:0]  pick_s;
  logic [CHW-1:0]  rr_idx_s;

  assign hs_s = req_valid_q && bus.req_ready;

  // Per-channel decode of config writes and of the channel being acknowledged.
  always_comb begin
    cfg_hit_s = {NCH{1'b0}};
    ack_s     = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      cfg_hit_s[c] = bus.cfg_we && (bus.cfg_ch == CHW'(c));
      ack_s[c]     = hs_s && (req_ch_q == CHW'(c));
    end
  end

  // Prescaler; the tick register is set for the cycle in which the count sits at DIV-1.
  always_comb begin
    if (presc_q == PS_LAST) begin
      presc_d = PSW'(0);
    end else begin
      presc_d = presc_q + PSW'(1);
    end
    base_tick_d = (presc_d == PS_LAST);
  end

  // Channel counters; a config write in a tick cycle wins and the tick is lost for that channel.
  always_comb begin
    period_d  = period_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    fire_s    = {NCH{1'b0}};
`ifdef SCHED_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif
    for (int c = 0; c < NCH; c++) begin
      if (cfg_hit_s[c]) begin
        period_d[c] = bus.cfg_period;
        en_d[c]     = bus.cfg_en;
        cnt_d[c]    = (bus.cfg_period == PERW'(0)) ? PERW'(0) : bus.cfg_period - PERW'(1);
`ifdef SCHED_ONESHOT_EN
        oneshot_d[c] = bus.cfg_oneshot;
`endif
      end else if (base_tick_q && en_q[c] && (period_q[c] != PERW'(0))) begin
        if (cnt_q[c] == PERW'(0)) begin
          fire_s[c] = 1'b1;
          cnt_d[c]  = period_q[c] - PERW'(1);
`ifdef SCHED_ONESHOT_EN
          if (oneshot_q[c]) begin
            en_d[c] = 1'b0;
          end else begin
            en_d[c] = en_q[c];
          end
`endif
        end else begin
          cnt_d[c] = cnt_q[c] - PERW'(1);
        end
      end else begin
        cnt_d[c] = cnt_q[c];
      end
    end
  end

  // Pending and sticky overrun; a fire coinciding with its own acknowledge re-arms pending cleanly.
  always_comb begin
    pending_d = (pending_q & ~ack_s) | fire_s;
    overrun_d = overrun_q;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_hit_s[c]) begin
        overrun_d[c] = 1'b0;
      end else if (fire_s[c] && pending_q[c] && !ack_s[c]) begin
        overrun_d[c] = 1'b1;
      end else begin
        overrun_d[c] = overrun_q[c];
      end
    end
  end

  // Round-robin search from the pointer; the channel acknowledged this cycle is excluded.
  always_comb begin
    cand_s   = pending_q & ~ack_s;
    found_s  = 1'b0;
    pick_s   = CHW'(0);
    rr_idx_s = CHW'(0);
    for (int unsigned i = 0; i < NCH; i++) begin
      rr_idx_s = CHW'((32'(ptr_q) + i) % NCH);
      if (!found_s && cand_s[rr_idx_s]) begin
        found_s = 1'b1;
        pick_s  = rr_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant register; a presented request is only replaced after its handshake.
  always_comb begin
    req_valid_d = req_valid_q;
    req_ch_d    = req_ch_q;
    ptr_d       = ptr_q;
    if (!req_valid_q || hs_s) begin
      if (found_s) begin
        req_valid_d = 1'b1;
        req_ch_d    = pick_s;
        ptr_d       = (32'(pick_s) == NCH - 1) ? CHW'(0) : pick_s + CHW'(1);
      end else begin
        req_valid_d = 1'b0;
      end
    end else begin
      req_valid_d = req_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= PSW'(0);
      base_tick_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        period_q[c] <= PERW'(0);
        cnt_q[c]    <= PERW'(0);
      end
      en_q        <= {NCH{1'b0}};
`ifdef SCHED_ONESHOT_EN
      oneshot_q   <= {NCH{1'b0}};
`endif
      pending_q   <= {NCH{1'b0}};
      overrun_q   <= {NCH{1'b0}};
      req_valid_q <= 1'b0;
      req_ch_q    <= CHW'(0);
      ptr_q       <= CHW'(0);
    end else begin
      presc_q     <= presc_d;
      base_tick_q <= base_tick_d;
      for (int c = 0; c < NCH; c++) begin
        period_q[c] <= period_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      en_q        <= en_d;
`ifdef SCHED_ONESHOT_EN
      oneshot_q   <= oneshot_d;
`endif
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      req_valid_q <= req_valid_d;
      req_ch_q    <= req_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign base_tick_o   = base_tick_q;
  assign pending_o     = pending_q;
  assign overrun_o     = overrun_q;
  assign bus.req_valid = req_valid_q;
  assign bus.req_ch    = req_ch_q;

  periodic_req_sched_chk #(.NCH(NCH)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_q),
    .req_ready_i (bus.req_ready),
    .req_ch_i    (req_ch_q),
    .pending_i   (pending_q)
  );
endmodule

// File: tb/tb_periodic_req_sched.sv
// Randomized bench for periodic_req_sched against a tick-counting reference model.
// Define SCHED_ONESHOT_EN to also exercise one-shot channels.
module tb_periodic_req_sched;
  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned BASE_HZ = 100;
  localparam int unsigned DIV     = CLK_HZ / BASE_HZ;
  localparam int unsigned NCH     = 4;
  localparam int unsigned PERW    = 16;
  localparam int unsigned CHW     = $clog2(NCH);
  localparam int unsigned VW      = 2 + CHW + 2 * NCH;

  logic           clk = 1'b0;
  logic           rst;
  logic           base_tick_o;
  logic [NCH-1:0] pending_o;
  logic [NCH-1:0] overrun_o;
  int             total = 0;
  int             bad   = 0;

  periodic_req_sched_if #(.NCH(NCH), .PERW(PERW)) bus ();

  periodic_req_sched #(.CLK_HZ(CLK_HZ), .BASE_HZ(BASE_HZ), .NCH(NCH), .PERW(PERW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .base_tick_o (base_tick_o),
    .pending_o   (pending_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  // Reference model: ticks counted since the last config write, fire every P-th tick.
  int unsigned     m_cycles;
  logic [PERW-1:0] m_per [NCH];
  bit              m_en [NCH];
  bit              m_one [NCH];
  int unsigned     m_since [NCH];
  logic [NCH-1:0]  m_pend, m_ovr;
  bit              m_valid;
  int unsigned     m_ch, m_ptr;

  function automatic bit m_tick();
    return (m_cycles % DIV) == DIV - 1;
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {base_tick_o, bus.req_valid, bus.req_ch, pending_o, overrun_o};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_tick(), m_valid, CHW'(m_ch), m_pend, m_ovr};
  endfunction

  task automatic step();
    bit             tick, hs, found;
    logic [NCH-1:0] fire, ack, cand;
    int unsigned    pick;
    tick = m_tick();
    if (rst) begin
      m_cycles = 0;
      for (int c = 0; c < NCH; c++) begin
        m_per[c] = '0; m_en[c] = 0; m_one[c] = 0; m_since[c] = 0;
      end
      m_pend = '0; m_ovr = '0; m_valid = 0; m_ch = 0; m_ptr = 0;
    end else begin
      hs  = m_valid && bus.req_ready;
      ack = '0;
      if (hs) ack[m_ch] = 1'b1;
      cand = m_pend & ~ack;
      fire = '0;
      for (int c = 0; c < NCH; c++) begin
        if (bus.cfg_we && bus.cfg_ch == c) begin
          m_per[c] = bus.cfg_period; m_en[c] = bus.cfg_en; m_since[c] = 0; m_ovr[c] = 1'b0;
`ifdef SCHED_ONESHOT_EN
          m_one[c] = bus.cfg_oneshot;
`endif
        end else if (tick && m_en[c] && m_per[c] != 0) begin
          m_since[c]++;
          if (m_since[c] % m_per[c] == 0) begin
            fire[c] = 1'b1;
            if (m_one[c]) m_en[c] = 0;
            if (m_pend[c] && !ack[c]) m_ovr[c] = 1'b1;
          end
        end
      end
      m_pend = cand | fire;
      if (!m_valid || hs) begin
        found = 0; pick = 0;
        for (int i = 0; i < NCH; i++) begin
          if (!found && cand[(m_ptr + i) % NCH]) begin
            found = 1; pick = (m_ptr + i) % NCH;
          end
        end
        if (found) begin
          m_valid = 1; m_ch = pick; m_ptr = (pick + 1) % NCH;
        end else begin
          m_valid = 0;
        end
      end
      m_cycles++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0; bus.cfg_en = 1'b0;
    bus.req_ready = 1'b0;
`ifdef SCHED_ONESHOT_EN
    bus.cfg_oneshot = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int per, input bit en);
    bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(ch); bus.cfg_period = PERW'(per); bus.cfg_en = en;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      total++;
      if (base_tick_o !== ((k % DIV) == DIV - 1)) begin
        bad++; $display("FAIL base_tick k=%0d got=%b", k, base_tick_o);
      end
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL reset_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_single_channel();
    int grants = 0;
    do_reset();
    bus.req_ready = 1'b1;
    cfg_write(1, 3, 1'b1);
    for (int k = 0; k < 95; k++) begin
      step();
      if (bus.req_valid && bus.req_ch == 1) grants++;
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL single_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
    total++;
    if (grants != 3 || overrun_o !== '0) begin
      bad++; $display("FAIL single_grants got=%0d/%b exp=3/0", grants, overrun_o);
    end
  endtask

  task automatic test_round_robin();
    int unsigned seq [$];
    do_reset();
    bus.req_ready = 1'b1;
    for (int c = 0; c < NCH; c++) cfg_write(c, 1, 1'b1);
    for (int k = 0; k < 56; k++) begin
      step();
      if (bus.req_valid) seq.push_back(bus.req_ch);
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL rr_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
    total++;
    if (seq.size() != 20) begin
      bad++; $display("FAIL rr_count got=%0d exp=20", seq.size());
    end
    foreach (seq[i]) begin
      total++;
      if (seq[i] != i % NCH) begin
        bad++; $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, seq[i], i % NCH);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cfg_write(2, 1, 1'b1);
    for (int k = 0; k < 25; k++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL bp_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
    total++;
    if ({bus.req_valid, bus.req_ch, pending_o[2], overrun_o[2]} !== {1'b1, CHW'(2), 1'b1, 1'b1}) begin
      bad++; $display("FAIL bp_hold got v=%b ch=%0d p=%b o=%b exp v=1 ch=2 p=1 o=1",
                      bus.req_valid, bus.req_ch, pending_o[2], overrun_o[2]);
    end
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    total++;
    if ({bus.req_valid, pending_o[2], overrun_o[2]} !== 3'b001) begin
      bad++; $display("FAIL bp_accept got v=%b p=%b o=%b exp v=0 p=0 o=1",
                      bus.req_valid, pending_o[2], overrun_o[2]);
    end
    cfg_write(2, 1, 1'b1);
    total++;
    if (overrun_o[2] !== 1'b0) begin
      bad++; $display("FAIL bp_cfg_clear got=%b exp=0", overrun_o[2]);
    end
  endtask

  task automatic test_collisions();
    do_reset();
    cfg_write(0, 1, 1'b1);
    for (int k = 0; k < 2 * DIV && !m_tick(); k++) step();
    repeat (2) step();
    for (int k = 0; k < 2 * DIV && !m_tick(); k++) step();
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    total++;
    if ({pending_o[0], overrun_o[0], bus.req_valid} !== 3'b100) begin
      bad++; $display("FAIL fire_ack got p=%b o=%b v=%b exp p=1 o=0 v=0",
                      pending_o[0], overrun_o[0], bus.req_valid);
    end
    step();
    total++;
    if ({bus.req_valid, bus.req_ch} !== {1'b1, CHW'(0)}) begin
      bad++; $display("FAIL fire_ack_rereq got v=%b ch=%0d exp v=1 ch=0", bus.req_valid, bus.req_ch);
    end
    for (int k = 0; k < 2 * DIV && !m_tick(); k++) step();
    cfg_write(1, 2, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL coll_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
      if (k == 10 || k == 20) begin
        total++;
        if (pending_o[1] !== (k == 20)) begin
          bad++; $display("FAIL cfg_tick k=%0d got=%b exp=%b", k, pending_o[1], k == 20);
        end
      end
    end
  endtask

`ifdef SCHED_ONESHOT_EN
  task automatic test_oneshot();
    int grants = 0;
    do_reset();
    bus.req_ready = 1'b1;
    bus.cfg_oneshot = 1'b1;
    cfg_write(3, 2, 1'b1);
    bus.cfg_oneshot = 1'b0;
    for (int k = 0; k < 105; k++) begin
      step();
      if (bus.req_valid && bus.req_ch == 3) grants++;
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL oneshot_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
    total++;
    if (grants != 1 || dut.en_q[3] !== 1'b0) begin
      bad++; $display("FAIL oneshot got grants=%0d en=%b exp 1/0", grants, dut.en_q[3]);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bus.cfg_we = ($urandom_range(0, 11) == 0);
      bus.cfg_ch = CHW'($urandom_range(0, NCH - 1));
      bus.cfg_period = PERW'($urandom_range(0, 5));
      bus.cfg_en = ($urandom_range(0, 9) != 0);
`ifdef SCHED_ONESHOT_EN
      bus.cfg_oneshot = ($urandom_range(0, 3) == 0);
`endif
      bus.req_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 399) == 0);
      step();
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL random_model k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_collisions();
`ifdef SCHED_ONESHOT_EN
    test_oneshot();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
